ext_mem_burst: RTL and testbench

Parametrised burst memory model serving as the external-memory slave for DMA engines in block and system testbenches. It is the successor to the fixed 32-bit, 1024-word model and adds the following:
- configurable data width and depth
- explicit per-beat write/read valid handshakes
- range checking with error codes
- a done pulse
- a deterministic FSM in place of event-waited loops
It must also be synthesizable so it can serve as an on-chip scratch memory in FPGA bring-up.

---
 rtl/ext_mem_pkg.sv | 17 +
 rtl/ext_mem_array.sv | 28 ++
 rtl/ext_mem_burst.sv | 168 ++++++++++++++++
 tb/tb_ext_mem_burst.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_pkg.sv
// Shared types and status codes for the ext_mem_burst memory model.
package ext_mem_pkg;

  typedef enum logic [2:0] {
    CLEAR,
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OK    = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_PROTO = 2'b11;

endpackage

// File: rtl/ext_mem_array.sv
// Single-port synchronous RAM with registered, enable-gated read port.
module ext_mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  // Read register only moves on a read so the last beat stays on the bus.
  always_ff @(posedge clk) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ext_mem_burst.sv
// Burst memory slave: edge-started write/read bursts with range checks,
// done pulse and status code, optional clear-on-reset sweep.
module ext_mem_burst
  import ext_mem_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 1024,
  parameter int ADDR_W         = 32,
  parameter int SIZE_W         = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_wdata,
  input  logic              m_wvalid,
  output logic [DATA_W-1:0] m_rdata,
  output logic              m_rvalid,
  input  logic              m_wenable,
  input  logic              m_renable,
  input  logic [SIZE_W-1:0] m_wsize,
  input  logic [SIZE_W-1:0] m_rsize,
  output logic              m_busy,
  output logic              m_done,
  output logic [1:0]        m_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CHK_W = IDX_W + SIZE_W + 1;

  state_t state, state_n;

  logic              wen_q, ren_q;
  logic              wstart, rstart, any_start;
  logic [SIZE_W-1:0] start_len;
  logic [1:0]        start_err;
  logic [CHK_W-1:0]  burst_end;

  logic [IDX_W-1:0]  base, clr_idx, addr;
  logic [SIZE_W-1:0] len, cnt;
  logic [1:0]        err;
  logic              we, re;
  logic [DATA_W-1:0] wdata;

  // Upper address bits beyond the word index are intentionally ignored.
  logic addr_unused;
  assign addr_unused = ^m_addr[ADDR_W-1:IDX_W];

  // Enable copies track the pins even through reset, so a level held across
  // reset or a burst never looks like a fresh start.
  always_ff @(posedge clk) begin
    wen_q <= m_wenable;
    ren_q <= m_renable;
  end

  always_comb begin
    wstart    = (state == IDLE) && m_wenable && !wen_q;
    rstart    = (state == IDLE) && m_renable && !ren_q;
    any_start = wstart || rstart;
    start_len = wstart ? m_wsize : m_rsize;
    burst_end = CHK_W'(m_addr[IDX_W-1:0]) + CHK_W'(start_len);
    if (wstart && rstart)              start_err = ERR_PROTO;
    else if (start_len == '0)          start_err = ERR_PROTO;
    else if (burst_end > CHK_W'(DEPTH)) start_err = ERR_RANGE;
    else                               start_err = ERR_NONE;
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      CLEAR: if (clr_idx == IDX_W'(DEPTH - 1)) state_n = IDLE;
      IDLE: begin
        if (any_start) begin
          if (start_err != ERR_NONE) state_n = DONE;
          else if (wstart)           state_n = WRITE;
          else                       state_n = READ;
        end
      end
      WRITE: if (m_wvalid && cnt == len - 1'b1) state_n = DONE;
      READ:  if (cnt == len) state_n = DONE;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    we     = 1'b0;
    re     = 1'b0;
    addr   = base + IDX_W'(cnt);
    wdata  = m_wdata;
    m_busy = 1'b0;
    m_done = 1'b0;
    case (state)
      CLEAR: begin
        we     = rstn;
        addr   = clr_idx;
        wdata  = '0;
        m_busy = 1'b1;
      end
      WRITE: begin
        we     = rstn && m_wvalid;
        m_busy = 1'b1;
      end
      READ: begin
        re     = (cnt != len);
        m_busy = 1'b1;
      end
      DONE:    m_done = 1'b1;
      default: ;
    endcase
  end

  // READ issues len addresses, then spends one more cycle presenting the
  // last registered beat before DONE.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt      <= '0;
      len      <= '0;
      base     <= '0;
      clr_idx  <= '0;
      err      <= ERR_NONE;
      m_rvalid <= 1'b0;
    end else begin
      m_rvalid <= re;
      case (state)
        CLEAR: clr_idx <= clr_idx + 1'b1;
        IDLE: begin
          if (any_start) begin
            base <= m_addr[IDX_W-1:0];
            len  <= start_len;
            cnt  <= '0;
            err  <= start_err;
          end
        end
        WRITE: begin
          if (m_wvalid) cnt <= cnt + 1'b1;
          if (state_n == DONE) err <= ERR_OK;
        end
        READ: begin
          if (cnt != len) cnt <= cnt + 1'b1;
          else            err <= ERR_OK;
        end
        default: ;
      endcase
    end
  end

  assign m_err = err;

  ext_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .re    (re),
    .addr  (addr),
    .wdata (wdata),
    .rdata (m_rdata)
  );

endmodule

// File: tb/tb_ext_mem_burst.sv
// Scoreboard bench for ext_mem_burst: three instances (clearing 32x1024,
// non-clearing 32x1024, clearing 64x256), one active at a time.
module tb_ext_mem_burst;
  import ext_mem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_wvalid, m_wenable, m_renable;
  logic [11:0] m_wsize, m_rsize;
  logic        rstn_a, rstn_b, rstn_c;

  logic [31:0] a_rdata, b_rdata;
  logic [63:0] c_rdata;
  logic        a_rvalid, b_rvalid, c_rvalid;
  logic        a_busy, b_busy, c_busy;
  logic        a_done, b_done, c_done;
  logic [1:0]  a_err, b_err, c_err;

  ext_mem_burst #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .SIZE_W(12), .CLEAR_ON_RESET(1'b1)) u_a (
    .clk(clk), .rstn(rstn_a), .m_addr(m_addr), .m_wdata(m_wdata[31:0]), .m_wvalid(m_wvalid),
    .m_rdata(a_rdata), .m_rvalid(a_rvalid), .m_wenable(m_wenable), .m_renable(m_renable),
    .m_wsize(m_wsize), .m_rsize(m_rsize), .m_busy(a_busy), .m_done(a_done), .m_err(a_err));

  ext_mem_burst #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32), .SIZE_W(12), .CLEAR_ON_RESET(1'b0)) u_b (
    .clk(clk), .rstn(rstn_b), .m_addr(m_addr), .m_wdata(m_wdata[31:0]), .m_wvalid(m_wvalid),
    .m_rdata(b_rdata), .m_rvalid(b_rvalid), .m_wenable(m_wenable), .m_renable(m_renable),
    .m_wsize(m_wsize), .m_rsize(m_rsize), .m_busy(b_busy), .m_done(b_done), .m_err(b_err));

  ext_mem_burst #(.DATA_W(64), .DEPTH(256), .ADDR_W(32), .SIZE_W(12), .CLEAR_ON_RESET(1'b1)) u_c (
    .clk(clk), .rstn(rstn_c), .m_addr(m_addr), .m_wdata(m_wdata), .m_wvalid(m_wvalid),
    .m_rdata(c_rdata), .m_rvalid(c_rvalid), .m_wenable(m_wenable), .m_renable(m_renable),
    .m_wsize(m_wsize), .m_rsize(m_rsize), .m_busy(c_busy), .m_done(c_done), .m_err(c_err));

  int          sel = 0;
  logic [63:0] mon_rdata;
  logic        mon_rvalid, mon_busy, mon_done;
  logic [1:0]  mon_err;

  always_comb begin
    case (sel)
      1:       begin mon_rdata = {32'h0, b_rdata}; mon_rvalid = b_rvalid; mon_busy = b_busy; mon_done = b_done; mon_err = b_err; end
      2:       begin mon_rdata = c_rdata;          mon_rvalid = c_rvalid; mon_busy = c_busy; mon_done = c_done; mon_err = c_err; end
      default: begin mon_rdata = {32'h0, a_rdata}; mon_rvalid = a_rvalid; mon_busy = a_busy; mon_done = a_done; mon_err = a_err; end
    endcase
  end

  typedef struct {
    logic [63:0] val;
    int          cyc;
  } exp_t;

  exp_t        rd_q[$];
  exp_t        dn_q[$];
  logic [63:0] shadow [0:1023];
  logic [63:0] dmask;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: every presented beat or done pulse must match the queue head,
  // both in value and in the cycle it was predicted for.
  always @(negedge clk) begin
    exp_t e;
    if (mon_rvalid) begin
      if (rd_q.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
      else begin
        e = rd_q.pop_front();
        check("rdata", mon_rdata, e.val);
        check("rbeat_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (mon_done) begin
      if (dn_q.size() == 0) check("done_unexpected", 64'd1, 64'd0);
      else begin
        e = dn_q.pop_front();
        check("err", 64'(mon_err), e.val);
        check("done_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_and_clear(input int which, input int depth, input bit clears);
    int n;
    sel = which;
    rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
    dmask = (which == 2) ? '1 : 64'h0000_0000_FFFF_FFFF;
    for (int i = 0; i < 1024; i++) shadow[i] = '0;
    tick(2);
    check("rst_rvalid", 64'(mon_rvalid), 64'd0);
    check("rst_done", 64'(mon_done), 64'd0);
    check("rst_err", 64'(mon_err), 64'(ERR_NONE));
    check("rst_rdata", mon_rdata, 64'd0);
    check("rst_busy", 64'(mon_busy), 64'(clears));
    case (which)
      1:       rstn_b = 1'b1;
      2:       rstn_c = 1'b1;
      default: rstn_a = 1'b1;
    endcase
    n = 0;
    while (mon_busy && n < depth + 20) begin
      tick(1);
      n++;
    end
    check("clear_cycles", 64'(n), clears ? 64'(depth) : 64'd0);
  endtask

  task automatic do_read(input int addr, input int len, input logic [1:0] exp_err);
    int c;
    m_addr = 32'(addr); m_rsize = len[11:0]; m_renable = 1'b1;
    c = cyc;
    if (exp_err == ERR_OK) begin
      for (int i = 0; i < len; i++) rd_q.push_back(exp_t'{shadow[addr + i], c + 2 + i});
      dn_q.push_back(exp_t'{64'(ERR_OK), c + len + 2});
    end else begin
      dn_q.push_back(exp_t'{64'(exp_err), c + 1});
    end
    tick(1);
    m_renable = 1'b0;
    tick(len + 3);
  endtask

  task automatic do_write(input int addr, input int len, input logic [63:0] d0,
                          input logic [15:0] stall, input logic [1:0] exp_err);
    int c, slot, beats;
    logic [63:0] d;
    m_addr = 32'(addr); m_wsize = len[11:0]; m_wenable = 1'b1;
    c = cyc;
    if (exp_err != ERR_OK) begin
      dn_q.push_back(exp_t'{64'(exp_err), c + 1});
      m_wvalid = 1'b1; m_wdata = d0;
      tick(1);
      m_wenable = 1'b0;
      tick(3);
    end else begin
      tick(1);
      m_wenable = 1'b0;
      slot = 0; beats = 0;
      while (beats < len) begin
        d = (d0 + 64'(beats)) & dmask;
        m_wvalid = (slot >= 16) || !stall[slot];
        m_wdata  = d;
        if (m_wvalid) begin
          shadow[addr + beats] = d;
          beats++;
          if (beats == len) dn_q.push_back(exp_t'{64'(ERR_OK), cyc + 1});
        end
        tick(1);
        slot++;
      end
    end
    m_wvalid = 1'b0;
    tick(2);
  endtask

  initial begin
    int c;
    m_addr = '0; m_wdata = '0; m_wvalid = 1'b0; m_wenable = 1'b0; m_renable = 1'b0;
    m_wsize = '0; m_rsize = '0;
    rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;

    // Cleared array reads back zero.
    reset_and_clear(0, 1024, 1'b1);
    do_read(0, 4, ERR_OK);

    // Gapped write, then read back; status and last beat held afterwards.
    do_write(8, 4, 64'hA0, 16'h0012, ERR_OK);
    do_read(8, 4, ERR_OK);
    check("err_held", 64'(mon_err), 64'(ERR_OK));
    check("rdata_hold", mon_rdata, 64'hA3);

    // Exact fit at the top, then an overflowing write that must not land.
    do_write(1020, 4, 64'hC0, 16'h0000, ERR_OK);
    do_write(1020, 8, 64'hE0, 16'h0000, ERR_RANGE);
    do_read(1020, 4, ERR_OK);
    check("range_keep", mon_rdata, 64'hC3);
    do_read(1021, 4, ERR_RANGE);
    do_read(1023, 1, ERR_OK);

    // Protocol errors: simultaneous starts, zero lengths.
    m_addr = 32'd0; m_wsize = 12'd4; m_rsize = 12'd4;
    m_wenable = 1'b1; m_renable = 1'b1;
    dn_q.push_back(exp_t'{64'(ERR_PROTO), cyc + 1});
    tick(1);
    m_wenable = 1'b0; m_renable = 1'b0;
    tick(3);
    do_read(0, 0, ERR_PROTO);
    do_write(16, 0, 64'h77, 16'h0000, ERR_PROTO);

    // Held enable starts exactly one burst.
    m_addr = 32'd8; m_rsize = 12'd2; m_renable = 1'b1;
    c = cyc;
    rd_q.push_back(exp_t'{64'hA0, c + 2});
    rd_q.push_back(exp_t'{64'hA1, c + 3});
    dn_q.push_back(exp_t'{64'(ERR_OK), c + 4});
    tick(12);
    m_renable = 1'b0;
    tick(2);

    // Reset in the middle of a 16-beat write on the non-clearing instance.
    reset_and_clear(1, 1024, 1'b0);
    do_write(0, 16, 64'h50, 16'h0000, ERR_OK);
    do_read(0, 16, ERR_OK);
    m_addr = 32'd0; m_wsize = 12'd16; m_wenable = 1'b1;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      m_wvalid = 1'b1;
      m_wdata  = 64'h100 + 64'(i);
      shadow[i] = 64'h100 + 64'(i);
      tick(1);
    end
    rstn_b = 1'b0; m_wenable = 1'b0; m_wdata = 64'hDEAD;
    tick(1);
    check("midrst_busy", 64'(mon_busy), 64'd0);
    check("midrst_rvalid", 64'(mon_rvalid), 64'd0);
    check("midrst_done", 64'(mon_done), 64'd0);
    check("midrst_err", 64'(mon_err), 64'(ERR_NONE));
    check("midrst_rdata", mon_rdata, 64'd0);
    rstn_b = 1'b1; m_wvalid = 1'b0;
    tick(2);
    do_read(0, 16, ERR_OK);

    // Wide, shallow instance: full-depth burst.
    reset_and_clear(2, 256, 1'b1);
    do_write(0, 256, 64'hDEAD_BEEF_0000_0000, 16'h0000, ERR_OK);
    do_read(0, 256, ERR_OK);
    check("wide_last", mon_rdata, 64'hDEAD_BEEF_0000_00FF);

    tick(5);
    check("rd_q_left", 64'(rd_q.size()), 64'd0);
    check("dn_q_left", 64'(dn_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
